// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: opcode encodings and fixed results.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_ROL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd11;
    localparam logic [3:0] OP_NAND = 4'd12;
    localparam logic [3:0] OP_XNOR = 4'd13;
    localparam logic [3:0] OP_GT   = 4'd14;
    localparam logic [3:0] OP_EQ   = 4'd15;

    // Quotient reported when dividing by zero (all ones at 8 bits).
    localparam logic [7:0] DIV0_RESULT = 8'hFF;

endpackage

// File: rtl/alu_if.sv
// Operand / opcode / result bundle between the control logic and the ALU.
interface alu_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_Sel;
    logic [WIDTH-1:0] ALU_Out;
    logic             CarryOut;

    // Control side: supplies operands and opcode, observes the result.
    modport master (
        output A, B, ALU_Sel,
        input  ALU_Out, CarryOut
    );

    // ALU side: consumes operands and opcode, produces the result.
    modport slave (
        input  A, B, ALU_Sel,
        output ALU_Out, CarryOut
    );
endinterface

// File: rtl/alu_core.sv
// Purely combinational opcode -> result/carry function of the ALU.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] prod_s;

    // Carry is always the carry of A+B, whatever the opcode.
    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign prod_s = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign carry  = sum_s[WIDTH];

    // Opcode decode; every encoding yields a defined value.
    always_comb begin
        result = {WIDTH{1'b0}};
        case (sel)
            OP_ADD:  result = sum_s[WIDTH-1:0];
            OP_SUB:  result = a - b;
            OP_MUL:  result = prod_s[WIDTH-1:0];
            OP_DIV: begin
                if (b == {WIDTH{1'b0}}) begin
                    result = WIDTH'(DIV0_RESULT);
                end else begin
                    result = a / b;
                end
            end
            OP_SHL:  result = {a[WIDTH-2:0], 1'b0};
            OP_SHR:  result = {1'b0, a[WIDTH-1:1]};
            OP_ROL:  result = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROR:  result = {a[0], a[WIDTH-1:1]};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_NAND: result = ~(a & b);
            OP_XNOR: result = ~(a ^ b);
            OP_GT:   result = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_EQ:   result = {{(WIDTH-1){1'b0}}, (a == b)};
            default: result = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered ALU: combinational core followed by a one-cycle output register.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    logic [WIDTH-1:0] core_out_s;
    logic             core_carry_s;
    logic [WIDTH-1:0] out_r;
    logic             carry_r;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (bus.A),
        .b      (bus.B),
        .sel    (bus.ALU_Sel),
        .result (core_out_s),
        .carry  (core_carry_s)
    );

    // Output register; reset clears it immediately and discards any pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
        end else begin
            out_r   <= core_out_s;
            carry_r <= core_carry_s;
        end
    end

    assign bus.ALU_Out  = out_r;
    assign bus.CarryOut = carry_r;

endmodule

// File: tb/tb_alu.sv
// Directed-vector self-checking bench for the registered ALU.
module tb_alu;

    logic clk;
    logic rst;
    logic clk_en;
    int   n_vec;
    int   n_err;

    alu_if #(.WIDTH(8)) bus ();

    alu #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Gated free-running clock so reset can be checked with no clock present.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    // Compare {CarryOut, ALU_Out} against the expected pair and count it.
    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got carry=%b out=%h, expected carry=%b out=%h",
                     tag, got[8], got[7:0], exp[8], exp[7:0]);
        end
    endtask

    function automatic logic [8:0] observed();
        return {bus.CarryOut, bus.ALU_Out};
    endfunction

    // Drive operands, let one posedge capture them, then check just after the edge.
    task automatic apply(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic [7:0] exp_out, input logic exp_c);
        bus.A       = a;
        bus.B       = b;
        bus.ALU_Sel = op;
        @(posedge clk);
        #1;
        check(tag, observed(), {exp_c, exp_out});
    endtask

    logic [7:0] sweep_exp [16];
    logic [3:0] op_v;

    initial begin
        n_vec  = 0;
        n_err  = 0;
        clk_en = 1'b0;
        sweep_exp = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                      8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};

        // 1. Reset with no clock running.
        bus.A = 8'h0A; bus.B = 8'h02; bus.ALU_Sel = 4'd0;
        rst = 1'b1;
        #3;
        check("reset_noclk", observed(), 9'h000);
        rst = 1'b0;
        #4;
        check("post_release_no_edge", observed(), 9'h000);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        check("first_capture", observed(), {1'b0, 8'h0C});

        // 2. Opcode sweep with a new opcode every cycle.
        for (int i = 0; i < 16; i++) begin
            op_v = 4'(i);
            apply($sformatf("sweep_op%0d", i), 8'h0A, 8'h02, op_v, sweep_exp[i], 1'b0);
        end
        op_v = op_v + 4'd1;
        apply("op_wrap_to_0", 8'h0A, 8'h02, op_v, 8'h0C, 1'b0);

        // 3. Carry and wrap-around; carry independent of opcode.
        apply("add_wrap",     8'hF6, 8'h0A, 4'd0, 8'h00, 1'b1);
        apply("and_carry",    8'hF6, 8'h0A, 4'd8, 8'h02, 1'b1);
        apply("sub_carry",    8'hF6, 8'h0A, 4'd1, 8'hEC, 1'b1);

        // 4. Edge arithmetic.
        apply("sub_underflow", 8'h00, 8'h01, 4'd1, 8'hFF, 1'b0);
        apply("mul_low",       8'hFF, 8'hFF, 4'd2, 8'h01, 1'b1);
        apply("div_by_zero",   8'h37, 8'h00, 4'd3, 8'hFF, 1'b0);
        apply("div_normal",    8'h64, 8'h07, 4'd3, 8'h0E, 1'b0);
        apply("rol_msb",       8'h81, 8'h02, 4'd6, 8'h03, 1'b0);
        apply("ror_lsb",       8'h81, 8'h02, 4'd7, 8'hC0, 1'b0);
        apply("shl_msb",       8'h81, 8'h02, 4'd4, 8'h02, 1'b0);
        apply("shr_msb",       8'h81, 8'h02, 4'd5, 8'h40, 1'b0);

        // 5. Unsigned compares.
        apply("eq_true",     8'h5A, 8'h5A, 4'd15, 8'h01, 1'b0);
        apply("gt_equal",    8'h5A, 8'h5A, 4'd14, 8'h00, 1'b0);
        apply("gt_unsigned", 8'h80, 8'h7F, 4'd14, 8'h01, 1'b0);

        // 6. Latency: new inputs must not show before the next posedge.
        bus.A = 8'h0F; bus.B = 8'hF0; bus.ALU_Sel = 4'd9;
        #2;
        check("hold_until_edge", observed(), {1'b0, 8'h01});
        @(posedge clk);
        #1;
        check("lag_one_edge", observed(), {1'b0, 8'hFF});

        // Mid-stream reset clears outputs without a clock edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_midstream", observed(), 9'h000);
        @(posedge clk);
        #1;
        check("reset_held", observed(), 9'h000);
        @(negedge clk);
        rst = 1'b0;
        bus.A = 8'hF6; bus.B = 8'h0A; bus.ALU_Sel = 4'd10;
        @(posedge clk);
        #1;
        check("after_reset", observed(), {1'b1, 8'hFC});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
